shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Serial frame controller built around a universal shift register core. It accepts a parallel word over a valid/ready handshake and loads it into the core. It then shifts the word out serially in the requested direction, capturing the same number of bits from the serial input, and presents the received word as a one-cycle result. It sits between a parallel producer/consumer and a serial pin pair.

## Interface
Parameters:
- WIDTH, 5, word and shift-register width in bits (≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- tx_valid  in  1  parallel word offered
- tx_ready  out  1  sequencer can accept a word this cycle
- tx_data  in  WIDTH  word to transmit
- tx_dir  in  1  0 = shift left (MSB first), 1 = shift right (LSB first); sampled at accept
- hold  in  1  pause shifting
- abort  in  1  cancel current frame
- sdi  in  1  serial data in
- sdo  out  1  serial data out
- busy  out  1  frame in progress
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_data  out  WIDTH  received word

## Operation
- States: IDLE, SHIFT, DONE.
- tx_ready = 1 in IDLE and DONE. tx_ready = 0 in SHIFT.
- busy = 1 only in SHIFT.
- rx_valid = 1 only in DONE.
- Accept occurs when tx_valid && tx_ready at a rising edge. At that edge:
  - core loads tx_data (sel LOAD);
  - dir register ← tx_dir;
  - counter ← WIDTH;
  - state → SHIFT.
- SHIFT with hold=0, abort=0:
  - core shifts left (sel LEFT, sdi enters bit 0) if dir=0, or right (sel RIGHT, sdi enters bit WIDTH-1) if dir=1;
  - counter decrements;
  - when counter reaches 1 at the edge, state → DONE.
- SHIFT with hold=1: core sel HOLD, counter frozen, sdo stable.
- SHIFT with abort=1: state → IDLE, no rx_valid. abort has priority over hold.
- abort and hold have no effect outside SHIFT.
- sdo = core bit WIDTH-1 if dir=0, core bit 0 if dir=1, only in SHIFT. sdo = 0 otherwise.
- DONE: rx_data = core contents.
  - If a word is accepted in the same cycle, load it and go to SHIFT (back-to-back frames).
  - Otherwise go to IDLE.
- rx_data = core contents in all states; it is only meaningful while rx_valid = 1.
- tx_valid is ignored while rst is asserted.
- Counter width is $clog2(WIDTH+1). No wrap: the counter never goes below 1 in SHIFT.

## Timing
- Accept at edge 0. Bit k (k = 0..WIDTH-1) of the frame appears on sdo in cycle k+1. sdi is sampled at edge k+1.
- With no hold, rx_valid is asserted in cycle WIDTH+1. The earliest next accept is edge WIDTH+1.
- Each hold cycle in SHIFT adds one cycle to frame latency.
- Reset (asynchronous, immediate):
  - state = IDLE, counter = 0, dir = 0, core = 0;
  - sdo = 0, busy = 0, rx_valid = 0, rx_data = 0, tx_ready = 1.
- Reset mid-frame discards the frame. No rx_valid is produced for it.

## Structure
- Package shift_seq_pkg contains:
  - state enum (IDLE, SHIFT, DONE);
  - sel encodings: SEL_HOLD = 2'b00, SEL_LEFT = 2'b01, SEL_RIGHT = 2'b10, SEL_LOAD = 2'b11.
- Sub-module usr_core: WIDTH-parameterized universal shift register.
  - Inputs: clk, rst (async, active-high), sel[1:0], par_in, si.
  - Output: q.
  - Encodings per package.
- shift_sequencer contains the FSM, counter, dir register, sdo mux and sel generation.

## Test plan
All scenarios use WIDTH=5.
- Left frame: tx_data = 5'b10110, tx_dir = 0, sdi held 1 → sdo = 1,0,1,1,0 in cycles 1–5; rx_valid in cycle 6 with rx_data = 5'b11111; busy high in cycles 1–5.
- Right frame: tx_data = 5'b10110, tx_dir = 1, sdi = 1,0,0,1,1 at edges 1–5 → sdo = 0,1,1,0,1; rx_data = 5'b11001 in cycle 6.
- Hold: the left frame above with hold high in cycles 3–5 → sdo stays 1 (bit 2) in cycles 3–5; the remaining bits follow in cycles 6–8; rx_valid in cycle 9.
- Abort: abort high in cycle 3 of a frame → IDLE at edge 3; tx_ready = 1 and busy = 0 in cycle 4; no rx_valid pulse.
- Back-to-back: tx_valid held high with words 5'b10110 then 5'b01001 → first rx_valid in cycle 6; second word accepted at edge 6; its first bit (0) on sdo in cycle 7; second rx_valid in cycle 12.
- Async reset: rst pulsed between edges in cycle 3 of a frame → sdo, busy, rx_valid and rx_data go to 0 and tx_ready goes to 1 immediately, without waiting for a clock edge; the next accept after release starts a clean frame.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
// Shared definitions for the shift sequencer slice.
//   state_t  : sequencer FSM states (IDLE, SHIFT, DONE)
//   SEL_*    : select encodings for the universal shift register core
// -----------------------------------------------------------------------------
package shift_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_LEFT  = 2'b01;
   localparam logic [1:0] SEL_RIGHT = 2'b10;
   localparam logic [1:0] SEL_LOAD  = 2'b11;

endpackage

// File: rtl/shift_sequencer_if.sv
// -----------------------------------------------------------------------------
// shift_sequencer_if
// Bundles the parallel handshake, frame control and serial pin signals of the
// shift sequencer.
//   master : parallel producer / serial pin driver side (drives tx_*, hold,
//            abort, sdi; observes tx_ready, sdo, busy, rx_*)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface shift_sequencer_if #(
   parameter int WIDTH = 5
);

   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] tx_data;
   logic             tx_dir;
   logic             hold;
   logic             abort;
   logic             sdi;
   logic             sdo;
   logic             busy;
   logic             rx_valid;
   logic [WIDTH-1:0] rx_data;

   modport master (
      output tx_valid, tx_data, tx_dir, hold, abort, sdi,
      input  tx_ready, sdo, busy, rx_valid, rx_data
   );

   modport slave (
      input  tx_valid, tx_data, tx_dir, hold, abort, sdi,
      output tx_ready, sdo, busy, rx_valid, rx_data
   );

endinterface

// File: rtl/shift_sequencer_usr_core.sv
// -----------------------------------------------------------------------------
// usr_core
// WIDTH-bit universal shift register: hold, shift left, shift right or
// parallel load, selected by sel.
//   clk, rst : clock, asynchronous active-high reset (clears q)
//   sel      : SEL_HOLD / SEL_LEFT / SEL_RIGHT / SEL_LOAD
//   par_in   : parallel load value
//   si       : serial input (enters bit 0 on left, bit WIDTH-1 on right)
//   q        : register contents
// -----------------------------------------------------------------------------
module usr_core
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] par_in,
   input  logic             si,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next register value for each operation
   always_comb begin
      q_d = q_q;
      case (sel)
         SEL_LEFT:  q_d = {q_q[WIDTH-2:0], si};
         SEL_RIGHT: q_d = {si, q_q[WIDTH-1:1]};
         SEL_LOAD:  q_d = par_in;
         default:   q_d = q_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Serial frame controller: accepts a parallel word over a valid/ready
// handshake, shifts it out on sdo in the requested direction while capturing
// the same number of bits from sdi, then presents the received word for one
// cycle on rx_valid/rx_data.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : shift_sequencer_if slave modport (tx handshake, hold, abort,
//              sdi/sdo, busy, rx_valid/rx_data)
// -----------------------------------------------------------------------------
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 5
) (
   input  logic              clk,
   input  logic              rst,
   shift_sequencer_if.slave  bus
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             busy_q, busy_d;
   logic             rx_valid_q, rx_valid_d;
   logic             tx_ready_q, tx_ready_d;
   logic [1:0]       sel;
   logic             accept;
   logic [WIDTH-1:0] core_q;

   assign accept = bus.tx_valid && tx_ready_q;

   // Next-state, counter, direction and core select. DONE behaves like IDLE
   // for accepts so frames can run back to back. Abort wins over hold, and
   // the counter stops moving once the last bit has been shifted.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      sel     = SEL_HOLD;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               sel     = SEL_LOAD;
               dir_d   = bus.tx_dir;
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (!bus.hold) begin
               sel   = dir_q ? SEL_RIGHT : SEL_LEFT;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d     = (state_d == SHIFT);
      rx_valid_d = (state_d == DONE);
      tx_ready_d = (state_d != SHIFT);
   end

   // FSM state plus its registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dir_q      <= 1'b0;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         busy_q     <= busy_d;
         rx_valid_q <= rx_valid_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   usr_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .sel    (sel),
      .par_in (bus.tx_data),
      .si     (bus.sdi),
      .q      (core_q)
   );

   // The outgoing bit is the end of the register that leaves first
   assign bus.sdo      = busy_q ? (dir_q ? core_q[0] : core_q[WIDTH-1]) : 1'b0;
   assign bus.busy     = busy_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.rx_data  = core_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Directed self-checking bench for shift_sequencer with WIDTH = 5.
// Cycle k is the interval between edge k-1 and edge k; inputs set in cycle k
// are sampled at edge k. Outputs are checked 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

   localparam int W = 5;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   shift_sequencer_if #(.WIDTH(W)) bus ();

   shift_sequencer #(
      .WIDTH (W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [W-1:0] data,
                                input logic dir, input logic sdiIn,
                                input logic holdIn, input logic abortIn);
      bus.tx_valid = valid;
      bus.tx_data  = data;
      bus.tx_dir   = dir;
      bus.sdi      = sdiIn;
      bus.hold     = holdIn;
      bus.abort    = abortIn;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Directed scenarios run back to back from a single reset
   initial begin
      logic [0:4] sdoExp;
      logic [0:4] sdiPat;
      logic [0:7] holdExp;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      applyStimulus(1'b1, 5'b10110, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput("reset_sdo", 8'(bus.sdo), 8'd0);
      checkOutput("reset_busy", 8'(bus.busy), 8'd0);
      checkOutput("reset_rx_valid", 8'(bus.rx_valid), 8'd0);
      checkOutput("reset_rx_data", 8'(bus.rx_data), 8'd0);
      checkOutput("reset_tx_ready", 8'(bus.tx_ready), 8'd1);
      tick();
      checkOutput("reset_ignores_valid", 8'(bus.busy), 8'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      $display("[TB] left frame");
      sdoExp = 5'b10110;
      applyStimulus(1'b1, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.tx_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("left_sdo_c%0d", k + 1), 8'(bus.sdo), 8'(sdoExp[k]));
         checkOutput($sformatf("left_busy_c%0d", k + 1), 8'(bus.busy), 8'd1);
         checkOutput($sformatf("left_ready_c%0d", k + 1), 8'(bus.tx_ready), 8'd0);
         tick();
      end
      checkOutput("left_rx_valid", 8'(bus.rx_valid), 8'd1);
      checkOutput("left_rx_data", 8'(bus.rx_data), 8'h1F);
      checkOutput("left_done_busy", 8'(bus.busy), 8'd0);
      checkOutput("left_done_ready", 8'(bus.tx_ready), 8'd1);
      tick();
      checkOutput("left_rx_valid_drop", 8'(bus.rx_valid), 8'd0);

      $display("[TB] right frame");
      sdoExp = 5'b01101;
      sdiPat = 5'b10011;
      applyStimulus(1'b1, 5'b10110, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bus.tx_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("right_sdo_c%0d", k + 1), 8'(bus.sdo), 8'(sdoExp[k]));
         bus.sdi = sdiPat[k];
         tick();
      end
      checkOutput("right_rx_valid", 8'(bus.rx_valid), 8'd1);
      checkOutput("right_rx_data", 8'(bus.rx_data), 8'b11001);
      tick();

      $display("[TB] hold frame");
      holdExp = 8'b10111110;
      applyStimulus(1'b1, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.tx_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         bus.hold = (k >= 3 && k <= 5);
         checkOutput($sformatf("hold_sdo_c%0d", k), 8'(bus.sdo), 8'(holdExp[k-1]));
         checkOutput($sformatf("hold_rx_valid_c%0d", k), 8'(bus.rx_valid), 8'd0);
         tick();
      end
      bus.hold = 1'b0;
      checkOutput("hold_rx_valid_c9", 8'(bus.rx_valid), 8'd1);
      checkOutput("hold_rx_data", 8'(bus.rx_data), 8'h1F);
      tick();

      $display("[TB] abort frame");
      applyStimulus(1'b1, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.tx_valid = 1'b0;
      tick();
      tick();
      checkOutput("abort_busy_c3", 8'(bus.busy), 8'd1);
      bus.abort = 1'b1;
      bus.hold  = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.hold  = 1'b0;
      checkOutput("abort_ready_c4", 8'(bus.tx_ready), 8'd1);
      checkOutput("abort_busy_c4", 8'(bus.busy), 8'd0);
      checkOutput("abort_sdo_c4", 8'(bus.sdo), 8'd0);
      for (int k = 4; k < 9; k++) begin
         checkOutput($sformatf("abort_no_rx_c%0d", k), 8'(bus.rx_valid), 8'd0);
         tick();
      end

      $display("[TB] back-to-back frames");
      sdoExp = 5'b01001;
      applyStimulus(1'b1, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.tx_data = 5'b01001;
      for (int k = 1; k <= 5; k++) begin
         checkOutput($sformatf("b2b_ready_c%0d", k), 8'(bus.tx_ready), 8'd0);
         tick();
      end
      checkOutput("b2b_rx_valid_c6", 8'(bus.rx_valid), 8'd1);
      checkOutput("b2b_rx_data_c6", 8'(bus.rx_data), 8'h1F);
      checkOutput("b2b_ready_c6", 8'(bus.tx_ready), 8'd1);
      tick();
      bus.tx_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("b2b_sdo_c%0d", k + 7), 8'(bus.sdo), 8'(sdoExp[k]));
         checkOutput($sformatf("b2b_busy_c%0d", k + 7), 8'(bus.busy), 8'd1);
         checkOutput($sformatf("b2b_rx_quiet_c%0d", k + 7), 8'(bus.rx_valid), 8'd0);
         tick();
      end
      checkOutput("b2b_rx_valid_c12", 8'(bus.rx_valid), 8'd1);
      checkOutput("b2b_rx_data_c12", 8'(bus.rx_data), 8'h1F);
      tick();
      checkOutput("b2b_rx_valid_c13", 8'(bus.rx_valid), 8'd0);

      $display("[TB] async reset mid-frame");
      applyStimulus(1'b1, 5'b10110, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.tx_valid = 1'b0;
      tick();
      tick();
      checkOutput("arst_pre_sdo", 8'(bus.sdo), 8'd1);
      checkOutput("arst_pre_rx_data", 8'(bus.rx_data), 8'b11011);
      #2;
      rst = 1'b1;
      bus.tx_valid = 1'b1;
      #1;
      checkOutput("arst_sdo", 8'(bus.sdo), 8'd0);
      checkOutput("arst_busy", 8'(bus.busy), 8'd0);
      checkOutput("arst_rx_valid", 8'(bus.rx_valid), 8'd0);
      checkOutput("arst_rx_data", 8'(bus.rx_data), 8'd0);
      checkOutput("arst_tx_ready", 8'(bus.tx_ready), 8'd1);
      bus.tx_valid = 1'b0;
      #1;
      rst = 1'b0;
      tick();
      checkOutput("arst_after_busy", 8'(bus.busy), 8'd0);
      checkOutput("arst_after_rx_valid", 8'(bus.rx_valid), 8'd0);
      sdoExp = 5'b11000;
      sdiPat = 5'b11010;
      applyStimulus(1'b1, 5'b00011, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      bus.tx_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("arst_frame_sdo_c%0d", k + 1), 8'(bus.sdo), 8'(sdoExp[k]));
         bus.sdi = sdiPat[k];
         tick();
      end
      checkOutput("arst_frame_rx_valid", 8'(bus.rx_valid), 8'd1);
      checkOutput("arst_frame_rx_data", 8'(bus.rx_data), 8'b01011);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
